sat_accumulator: RTL and testbench

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

---
 rtl/sat_accumulator_if.sv | 40 ++++
 rtl/sat_accumulator.sv | 115 +++++++++++
 tb/tb_sat_accumulator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sat_accumulator_if.sv
// Handshake and result bundle for sat_accumulator: operand stream in, saturated result out.
// Latency: none; this is only a bundle of wires.
// Backpressure: in_valid_80/in_ready_80 on the operand side, out_valid_80/out_ready_80 on the result side.
// Ports: master = producer/consumer side (testbench or upstream logic), slave = the accumulator.
// SAT_COUNT_EN adds the 8-bit sat_cnt_80 result field.
interface sat_accumulator_if #(
  parameter int WIDTH_SUM = 4
);
  logic                 in_valid_80;
  logic                 in_ready_80;
  logic [WIDTH_SUM-1:0] in_data_80;
  logic                 out_valid_80;
  logic                 out_ready_80;
  logic [WIDTH_SUM-1:0] sum_80;
  logic                 carry_80;
  logic                 oflow_80;
`ifdef SAT_COUNT_EN
  logic [7:0]           sat_cnt_80;

  modport master (
    output in_valid_80, in_data_80, out_ready_80,
    input  in_ready_80, out_valid_80, sum_80, carry_80, oflow_80, sat_cnt_80
  );

  modport slave (
    input  in_valid_80, in_data_80, out_ready_80,
    output in_ready_80, out_valid_80, sum_80, carry_80, oflow_80, sat_cnt_80
  );
`else
  modport master (
    output in_valid_80, in_data_80, out_ready_80,
    input  in_ready_80, out_valid_80, sum_80, carry_80, oflow_80
  );

  modport slave (
    input  in_valid_80, in_data_80, out_ready_80,
    output in_ready_80, out_valid_80, sum_80, carry_80, oflow_80
  );
`endif
endinterface

// File: rtl/sat_accumulator.sv
// Saturating signed accumulator: sums NUM_TERMS operands into a symmetric-range result.
// Latency: result valid the cycle after the NUM_TERMS-th accepted operand; one cycle idle after result handshake.
// Backpressure: in_ready_80 is low while a result waits in DONE; the result is held until out_ready_80.
// Ports: clk_80, reset_n_80 (async, active-low), bus (sat_accumulator_if.slave).
// Optional macro SAT_COUNT_EN adds a saturating count of overflow-saturated additions on bus.sat_cnt_80.
module sat_accumulator #(
  parameter int WIDTH_SUM = 4,
  parameter int NUM_TERMS = 4
) (
  input  logic               clk_80,
  input  logic               reset_n_80,
  sat_accumulator_if.slave   bus
);

  localparam int CNT_W = (NUM_TERMS > 2) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0]     LAST_TERM = CNT_W'(NUM_TERMS - 1);
  localparam logic [WIDTH_SUM-1:0] MAX_POS   = {1'b0, {(WIDTH_SUM-1){1'b1}}};
  localparam logic [WIDTH_SUM-1:0] MIN_NEG   = {1'b1, {(WIDTH_SUM-2){1'b0}}, 1'b1};
  localparam logic [WIDTH_SUM-1:0] ILLEGAL   = {1'b1, {(WIDTH_SUM-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state, state_nxt;
  logic                 in_ready, out_valid, accept, done_hs, last_term;
  logic [CNT_W-1:0]     term_cnt;
  logic [WIDTH_SUM-1:0] acc, operand, raw_res, acc_nxt;
  logic [WIDTH_SUM:0]   raw;
  logic                 ovf, oflow_seq;
  logic [WIDTH_SUM-1:0] sum_r;
  logic                 carry_r, oflow_r;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_80 or negedge reset_n_80) begin
    if (!reset_n_80) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // Gated by reset so the producer sees no ready while reset is held.
    in_ready  = (state != DONE) && reset_n_80;
    out_valid = (state == DONE);
    accept    = bus.in_valid_80 && in_ready;
    done_hs   = out_valid && bus.out_ready_80;
    last_term = (term_cnt == LAST_TERM);
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (accept && last_term) state_nxt = DONE;
      DONE:    if (done_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- saturating adder ----------------
  always_comb begin
    // The asymmetric most-negative code is outside the legal range; pull it in.
    operand = (bus.in_data_80 == ILLEGAL) ? MIN_NEG : bus.in_data_80;
    raw     = {1'b0, acc} + {1'b0, operand};
    raw_res = raw[WIDTH_SUM-1:0];
    ovf     = (acc[WIDTH_SUM-1] == operand[WIDTH_SUM-1]) &&
              (raw_res[WIDTH_SUM-1] != operand[WIDTH_SUM-1]);
    if (ovf && !operand[WIDTH_SUM-1])  acc_nxt = MAX_POS;
    else if (ovf)                      acc_nxt = MIN_NEG;
    // A legal sum can still land on the illegal code (e.g. -4 + -4 at 4 bits);
    // clamp it without flagging overflow.
    else if (raw_res == ILLEGAL)       acc_nxt = MIN_NEG;
    else                               acc_nxt = raw_res;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_80 or negedge reset_n_80) begin
    if (!reset_n_80) begin
      acc       <= '0;
      term_cnt  <= '0;
      oflow_seq <= 1'b0;
      sum_r     <= '0;
      carry_r   <= 1'b0;
      oflow_r   <= 1'b0;
    end else if (accept) begin
      acc       <= acc_nxt;
      oflow_seq <= oflow_seq | ovf;
      if (last_term) begin
        // Result registers only change on DONE entry so they hold through IDLE/ACCUM.
        sum_r   <= acc_nxt;
        carry_r <= raw[WIDTH_SUM];
        oflow_r <= oflow_seq | ovf;
      end else begin
        term_cnt <= term_cnt + 1'b1;
      end
    end else if (done_hs) begin
      acc       <= '0;
      term_cnt  <= '0;
      oflow_seq <= 1'b0;
    end
  end

`ifdef SAT_COUNT_EN
  logic [7:0] sat_cnt;

  // Lifetime count across sequences; only reset clears it.
  always_ff @(posedge clk_80 or negedge reset_n_80) begin
    if (!reset_n_80)                       sat_cnt <= 8'd0;
    else if (accept && ovf && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
  end

  assign bus.sat_cnt_80 = sat_cnt;
`endif

  assign bus.in_ready_80  = in_ready;
  assign bus.out_valid_80 = out_valid;
  assign bus.sum_80       = sum_r;
  assign bus.carry_80     = carry_r;
  assign bus.oflow_80     = oflow_r;

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator (WIDTH_SUM=4, NUM_TERMS=4).
// Stimulus pushes hand-computed results; a monitor pops on each result handshake.
// Also checks reset values, result latency, DONE stalling and mid-sequence reset.
module tb_sat_accumulator;

  logic clk;
  logic rst_n;

  sat_accumulator_if #(.WIDTH_SUM(4)) bus ();

  sat_accumulator #(.WIDTH_SUM(4), .NUM_TERMS(4)) dut (
    .clk_80     (clk),
    .reset_n_80 (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sum;
    logic       carry;
    logic       oflow;
    logic [7:0] sat;
  } exp_t;

  typedef struct packed {
    logic [15:0] ops;   // op0 in [15:12]
    logic [3:0]  sum;
    logic        carry;
    logic        oflow;
    logic [7:0]  nsat;  // overflow-saturated additions in this sequence
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_sat  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_80 && bus.out_ready_80) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result actual=%0h expected=none", bus.sum_80);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_sum",   bus.sum_80,   e.sum);
        check("sb_carry", bus.carry_80, e.carry);
        check("sb_oflow", bus.oflow_80, e.oflow);
`ifdef SAT_COUNT_EN
        check("sb_sat_cnt", bus.sat_cnt_80, e.sat);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_op(input logic [3:0] d);
    int t;
    bus.in_valid_80 = 1'b1;
    bus.in_data_80  = d;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready_80 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1 bus.in_valid_80 = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    exp_sat = (exp_sat + int'(v.nsat) > 255) ? 255 : exp_sat + int'(v.nsat);
    e.sum   = v.sum;
    e.carry = v.carry;
    e.oflow = v.oflow;
    e.sat   = 8'(exp_sat);
    sb.push_back(e);
  endtask

  task automatic run_seq(input vec_t v, input bit gap);
    logic [15:0] ops;
    ops = v.ops;
    push_exp(v);
    for (int i = 0; i < 4; i++) begin
      send_op(ops[15-4*i -: 4]);
      if (i == 2) begin
        #2 check("no_early_valid", bus.out_valid_80, 1'b0);
      end
      if (gap && i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check("valid_latency", bus.out_valid_80, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'h1231, 4'h7, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{16'h55EF, 4'h4, 1'b1, 1'b1, 8'd1};
    vecs[2] = '{16'hCC00, 4'h9, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{16'h8100, 4'hA, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{16'hFFFF, 4'hC, 1'b1, 1'b0, 8'd0};
    vecs[5] = '{16'h7777, 4'h7, 1'b0, 1'b1, 8'd3};
    vecs[6] = '{16'h9900, 4'h9, 1'b0, 1'b1, 8'd1};

    rst_n            = 1'b0;
    bus.in_valid_80  = 1'b0;
    bus.in_data_80   = 4'h0;
    bus.out_ready_80 = 1'b1;

    #3;
    check("rst_in_ready",  bus.in_ready_80,  1'b0);
    check("rst_out_valid", bus.out_valid_80, 1'b0);
    check("rst_sum",       bus.sum_80,       4'h0);
    check("rst_carry",     bus.carry_80,     1'b0);
    check("rst_oflow",     bus.oflow_80,     1'b0);
`ifdef SAT_COUNT_EN
    check("rst_sat_cnt",   bus.sat_cnt_80,   8'd0);
`endif
    #9 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready_80, 1'b1);
    @(posedge clk);
    #1;

    for (int r = 0; r < 7; r++) run_seq(vecs[r], r[0]);

    // Hold the result with out_ready low while offering a stray operand.
    @(posedge clk);
    #1 bus.out_ready_80 = 1'b0;
    run_seq(vecs[0], 1'b0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      bus.in_valid_80 = 1'b1;
      bus.in_data_80  = 4'h7;
      @(negedge clk);
      check("stall_valid",    bus.out_valid_80, 1'b1);
      check("stall_in_ready", bus.in_ready_80,  1'b0);
      check("stall_sum",      bus.sum_80,       4'h7);
      check("stall_oflow",    bus.oflow_80,     1'b0);
      @(posedge clk);
    end
    #1;
    bus.in_valid_80  = 1'b0;
    bus.out_ready_80 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid",    bus.out_valid_80, 1'b0);
    check("post_hs_in_ready", bus.in_ready_80,  1'b1);
    check("post_hs_sum_hold", bus.sum_80,       4'h7);
    @(posedge clk);
    #1;
    run_seq(vecs[4], 1'b0);
    run_seq(vecs[6], 1'b1);

    // Reset after two accepts of a new sequence.
    @(posedge clk);
    #1;
    send_op(4'h3);
    send_op(4'h3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  bus.in_ready_80,  1'b0);
    check("mid_rst_out_valid", bus.out_valid_80, 1'b0);
    check("mid_rst_sum",       bus.sum_80,       4'h0);
    check("mid_rst_carry",     bus.carry_80,     1'b0);
    check("mid_rst_oflow",     bus.oflow_80,     1'b0);
`ifdef SAT_COUNT_EN
    check("mid_rst_sat_cnt",   bus.sat_cnt_80,   8'd0);
`endif
    exp_sat = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release_ready", bus.in_ready_80, 1'b1);
    @(posedge clk);
    #1;
    run_seq('{16'h1111, 4'h4, 1'b0, 1'b0, 8'd0}, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
